// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, bit-time and frame-length helpers, parity.
// Both the receive deframer and the transmitter use these.
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;
  localparam logic [2:0] S_BREAK  = 3'd6;

  typedef struct packed {
    logic [1:0] baud;
    logic [1:0] len;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } uart_cfg_t;

  // 0: base, 1: x2, 2: x4, 3: /2 clocks per bit
  function automatic int unsigned bit_clks(input logic [1:0] baud_sel, input int unsigned base);
    case (baud_sel)
      2'd1:    return base << 1;
      2'd2:    return base << 2;
      2'd3:    return base >> 1;
      default: return base;
    endcase
  endfunction

  function automatic logic [3:0] data_bits(input logic [1:0] len_sel);
    return 4'd5 + {2'b00, len_sel};
  endfunction

  // Parity bit that makes the frame valid; unused data bits must be zero.
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module uart_bit_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: mid-bit sampling of the synchronized Rx line into bytes plus
// parity/framing flags. Settings are captured at each start edge. SYNC_STAGES >= 2.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int BIT_CLKS_BASE = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  input  logic [1:0] baud_sel,
  input  logic [1:0] len_sel,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop2,
  output logic [7:0] rx_data,
  output logic [8:0] rx_frame,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int TW = $clog2(BIT_CLKS_BASE * 4);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_prev_q;

  logic [2:0]  state_q, state_d;
  uart_cfg_t   cfg_q, cfg_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        par_q, par_d, perr_q, perr_d, ferr_q, ferr_d;
  logic        ld, tc, fin;
  logic [TW-1:0] ld_val, full_val, half_val;

  logic [7:0]  rx_data_q;
  logic [8:0]  rx_frame_q;
  logic        rx_valid_q, parity_err_q, frame_err_q;

  // Synchronizer idles high so reset release never looks like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], Rx};
      rxs_prev_q <= rxs;
    end
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  assign full_val = TW'(bit_clks(cfg_q.baud, BIT_CLKS_BASE) - 1);
  assign half_val = TW'((bit_clks(baud_sel, BIT_CLKS_BASE) >> 1) - 1);

  uart_bit_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld),
    .load_val_i (ld_val),
    .tc_o       (tc)
  );

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ld      = 1'b0;
    ld_val  = full_val;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: if (rxs_prev_q && !rxs) begin
        cfg_d   = {baud_sel, len_sel, parity_en, parity_odd, stop2};
        ld      = 1'b1;
        ld_val  = half_val;
        state_d = S_START;
      end
      S_START: if (tc) begin
        if (rxs) state_d = S_IDLE;
        else begin
          ld      = 1'b1;
          idx_d   = '0;
          data_d  = '0;
          par_d   = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: if (tc) begin
        data_d[idx_q[2:0]] = rxs;
        idx_d = idx_q + 4'd1;
        ld    = 1'b1;
        if (idx_q == data_bits(cfg_q.len) - 4'd1)
          state_d = cfg_q.par_en ? S_PARITY : S_STOP1;
      end
      S_PARITY: if (tc) begin
        par_d   = rxs;
        perr_d  = parity_bit(data_q, cfg_q.par_odd) ^ rxs;
        ld      = 1'b1;
        state_d = S_STOP1;
      end
      S_STOP1: if (tc) begin
        ferr_d = ferr_q | !rxs;
        if (cfg_q.stop2 && rxs) begin
          ld      = 1'b1;
          state_d = S_STOP2;
        end else fin = 1'b1;
      end
      S_STOP2: if (tc) begin
        ferr_d = ferr_q | !rxs;
        fin    = 1'b1;
      end
      S_BREAK: if (rxs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Leave at mid-stop so a back-to-back start edge is still caught
    if (fin) state_d = ferr_d ? S_BREAK : S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_frame_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_valid_q <= fin;
      if (fin) begin
        rx_data_q    <= data_q;
        rx_frame_q   <= {cfg_q.par_en & par_q, data_q};
        parity_err_q <= cfg_q.par_en & perr_q;
        frame_err_q  <= ferr_d;
      end
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign rx_frame   = rx_frame_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: frame-level reference model plus scoreboard
// checked on every strobe, with literal spot checks.
module tb_uart_rx_deframer;
  logic       clk = 1'b0, rst = 1'b1, Rx = 1'b1;
  logic [1:0] baud_sel = 2'd0, len_sel = 2'd3;
  logic       parity_en = 1'b1, parity_odd = 1'b0, stop2 = 1'b0;
  logic [7:0] rx_data;
  logic [8:0] rx_frame;
  logic       rx_valid, parity_err, frame_err, busy;

  int checks = 0, errors = 0, nstrobes = 0;
  bit abort = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic [8:0] f;
    logic       pe;
    logic       fe;
    bit         dc;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  uart_rx_deframer #(.BIT_CLKS_BASE(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .Rx(Rx), .baud_sel(baud_sel), .len_sel(len_sel),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .rx_data(rx_data), .rx_frame(rx_frame), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame result from what was put on the line and the config at the start edge
  function automatic exp_t model(input logic [7:0] d, input int nb, input logic p,
                                 input logic s1, input logic s2);
    exp_t e;
    logic [7:0] m;
    int ones;
    m    = d & 8'((1 << nb) - 1);
    ones = $countones(m) + int'(p);
    e.d  = m;
    e.pe = parity_en && ((ones % 2) != int'(parity_odd));
    e.fe = !s1 || (stop2 && !s2);
    e.f  = {parity_en && p, m};
    e.dc = 1'b0;
    return e;
  endfunction

  task automatic bit_out(input logic v, input int bns);
    if (!abort) begin
      Rx = v;
      #(bns);
    end
  endtask

  task automatic send(input logic [7:0] d, input int nb, input logic p, input logic s1,
                      input logic s2, input int nstop, input int bns);
    bit_out(1'b0, bns);
    for (int i = 0; i < nb; i++) bit_out(d[i], bns);
    if (parity_en) bit_out(p, bns);
    bit_out(s1, bns);
    if (nstop == 2) bit_out(s2, bns);
    Rx = 1'b1;
    if (!abort) #(2 * bns);
  endtask

  task automatic frame(input logic [7:0] d, input int nb, input logic p, input logic s1,
                       input logic s2, input int nstop, input int bns);
    expq.push_back(model(d, nb, p, s1, (nstop == 2) ? s2 : 1'b1));
    send(d, nb, p, s1, s2, nstop, bns);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_strobe_timeout: pending %0d expected 0", name, expq.size());
      expq.delete();
    end
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1 chk({name, "_idle"}, busy, 0);
  endtask

  // Scoreboard: every strobe must match the next expected frame
  initial begin : cmp
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev_v = 1'b0;
      else begin
        if (rx_valid) begin
          nstrobes++;
          checks++;
          if (prev_v) begin
            errors++;
            $display("FAIL strobe_width: rx_valid high on consecutive cycles");
          end else if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: data %0h frame %0h, expected no strobe", rx_data, rx_frame);
          end else begin
            e = expq.pop_front();
            if (e.dc) begin
              if (rx_data == e.d && !frame_err) begin
                errors++;
                $display("FAIL mismatched_baud: data %0h ferr %0b, expected corrupt data or ferr", rx_data, frame_err);
              end
            end else if ({rx_data, rx_frame, parity_err, frame_err} !== {e.d, e.f, e.pe, e.fe}) begin
              errors++;
              $display("FAIL frame: got d=%0h f=%0h pe=%0b fe=%0b expected d=%0h f=%0h pe=%0b fe=%0b",
                       rx_data, rx_frame, parity_err, frame_err, e.d, e.f, e.pe, e.fe);
            end
          end
        end
        prev_v = rx_valid;
      end
    end
  end

  initial begin : stim
    exp_t e;
    int   n0;
    #23;
    chk("reset_data", rx_data, 0);
    chk("reset_frame", rx_frame, 0);
    chk("reset_valid", rx_valid, 0);
    chk("reset_perr", parity_err, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);

    // Pin the model against hand-derived results
    e = model(8'h3A, 8, 1'b0, 1'b1, 1'b1);
    chk("model_pin_frame", {e.pe, e.fe, e.f}, {2'b00, 9'h03A});
    e = model(8'hFF, 6, 1'b1, 1'b0, 1'b1);
    chk("model_pin_mask", {e.pe, e.fe, e.f}, {2'b11, 9'h13F});

    // Default config, 0x3A, even parity 0
    frame(8'h3A, 8, 1'b0, 1'b1, 1'b1, 1, 320);
    drain("default");
    chk("default_data", rx_data, 8'h3A);
    chk("default_frame", rx_frame, 9'h03A);
    chk("default_flags", {parity_err, frame_err}, 2'b00);

    // Half rate, then a frame at the wrong rate
    baud_sel = 2'd1;
    frame(8'h3A, 8, 1'b0, 1'b1, 1'b1, 1, 640);
    drain("baud1");
    chk("baud1_data", rx_data, 8'h3A);
    e = model(8'h7A, 8, 1'b1, 1'b1, 1'b1);
    e.dc = 1'b1;
    expq.push_back(e);
    send(8'h7A, 8, 1'b1, 1'b1, 1'b1, 1, 320);
    drain("baud_mismatch");

    // 6 data bits; config flipped mid-frame must not matter
    baud_sel = 2'd0;
    len_sel  = 2'd1;
    expq.push_back(model(8'h3A, 6, 1'b0, 1'b1, 1'b1));
    fork
      send(8'h3A, 6, 1'b0, 1'b1, 1'b1, 1, 320);
      begin #(3 * 320); len_sel = 2'd3; baud_sel = 2'd2; end
    join
    drain("len6");
    chk("len6_data", rx_data, 8'h3A);
    chk("len6_flags", {parity_err, frame_err}, 2'b00);
    baud_sel = 2'd0;

    // Odd parity
    parity_odd = 1'b1;
    frame(8'h3A, 8, 1'b0, 1'b1, 1'b1, 1, 320);
    drain("odd_bad");
    chk("odd_bad_perr", parity_err, 1);
    frame(8'h3A, 8, 1'b1, 1'b1, 1'b1, 1, 320);
    drain("odd_good");
    chk("odd_good_perr", parity_err, 0);

    // Two stop bits, second one low
    stop2 = 1'b1;
    frame(8'h3A, 8, 1'b1, 1'b1, 1'b0, 2, 320);
    drain("stop2_low");
    chk("stop2_low_ferr", frame_err, 1);

    // Line held low: exactly one errored frame, busy until the line recovers
    expq.push_back(model(8'h00, 8, 1'b0, 1'b0, 1'b0));
    n0 = nstrobes;
    Rx = 1'b0;
    #(20 * 320);
    chk("break_one_strobe", nstrobes, n0 + 1);
    chk("break_busy_held", busy, 1);
    chk("break_flags", {parity_err, frame_err}, 2'b11);
    Rx = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("break_busy_released", busy, 0);

    // Two-stop frame while expecting one
    stop2 = 1'b0;
    parity_odd = 1'b0;
    frame(8'hC3, 8, 1'b0, 1'b1, 1'b1, 2, 320);
    drain("extra_stop");

    // Fastest rate, no parity
    baud_sel  = 2'd3;
    parity_en = 1'b0;
    frame(8'h5C, 8, 1'b0, 1'b1, 1'b1, 1, 160);
    drain("baud3");
    chk("baud3_frame", rx_frame, 9'h05C);

    // Reset in the middle of a frame
    baud_sel  = 2'd0;
    parity_en = 1'b1;
    n0 = nstrobes;
    fork
      send(8'hA5, 8, 1'b0, 1'b1, 1'b1, 1, 320);
      begin
        #(5 * 320);
        rst = 1'b1;
        abort = 1'b1;
        #1;
        chk("midrst_data", rx_data, 0);
        chk("midrst_frame", rx_frame, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rx_valid, 0);
      end
    join
    Rx = 1'b1;
    abort = 1'b0;
    #100 rst = 1'b0;
    repeat (100) @(posedge clk);
    chk("midrst_no_strobe", nstrobes, n0);
    frame(8'h55, 8, 1'b0, 1'b1, 1'b1, 1, 320);
    drain("after_rst");
    chk("after_rst_data", rx_data, 8'h55);

    // Short glitch is rejected at the start-bit sample
    n0 = nstrobes;
    Rx = 1'b0;
    #80 Rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("glitch_no_strobe", nstrobes, n0);
    chk("glitch_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side deframer of the UART path. Takes the raw serial `Rx` pin and produces parallel bytes with error flags.
- Feeds the command/config decoder and the debug frame display.
- Baud rate, frame length, parity enable/type and stop-bit count are runtime inputs driven by the config register block.
- All settings are latched per frame at start-bit detection.

Parameters:
- BIT_CLKS_BASE, 32, clocks per bit at the base rate (9600 setting); must be even, 8 or more.
- SYNC_STAGES, 2, number of metastability flops on `Rx`.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- Rx  in  1  serial input, idle high
- baud_sel  in  2  0: BIT_CLKS_BASE; 1: x2 (4800); 2: x4 (2400); 3: /2 (19200)
- len_sel  in  2  data bits = 5 + len_sel (0..3 gives 5..8)
- parity_en  in  1  1 = a parity bit follows the data bits
- parity_odd  in  1  1 = odd parity, 0 = even
- stop2  in  1  1 = two stop bits are expected
- rx_data  out  8  received data, LSB first on the line, zero-extended above len
- rx_frame  out  9  {parity bit as received, or 0 when parity is disabled; rx_data}, for debug display
- rx_valid  out  1  one-cycle strobe marking rx_data, rx_frame and the error flags as new
- parity_err  out  1  parity mismatch on the last frame
- frame_err  out  1  a stop bit sampled low on the last frame
- busy  out  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (asynchronous, applies at any time, including mid-frame):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Synchronizer flops reset to 1, so no false start follows reset release.
  - A partially received frame is discarded and never reported.
- `Rx` passes through SYNC_STAGES flops. All timing below refers to the synchronized signal `rxs`.
- Bit time T is selected by baud_sel: 32, 64, 128 or 16 clocks with default parameters.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
  - IDLE:
    - On a 1-to-0 transition of `rxs`, latch baud_sel, len_sel, parity_en, parity_odd and stop2.
    - Load the counter with T/2 - 1, go to START, set busy.
  - START:
    - At counter 0, sample `rxs`.
    - If the sample is 1 (glitch), return to IDLE with no strobe.
    - If the sample is 0, reload T - 1, clear the bit index, go to DATA.
  - DATA:
    - At each counter 0, shift `rxs` into bit[idx] and increment idx.
    - After 5 + len bits, go to PARITY if parity_en, else STOP1.
    - Reload T - 1 on every sample.
  - PARITY:
    - Sample the parity bit p.
    - Compute e = XOR of the received data bits XOR p XOR parity_odd; e = 1 means a parity error.
  - STOP1:
    - Sample. A 0 sets the pending frame_err.
    - If stop2 and no error so far, go to STOP2; otherwise finish.
  - STOP2:
    - Sample. A 0 sets the pending frame_err, then finish.
  - Finish:
    - In the cycle after the last stop sample, pulse rx_valid for 1 cycle.
    - On that cycle, load rx_data, rx_frame, parity_err and frame_err.
    - These outputs hold until the next rx_valid.
  - Next state after finish:
    - If frame_err is pending, go to BREAK.
    - Otherwise go to IDLE at mid-stop-bit, so the next start edge can be caught with zero idle gap.
  - BREAK: wait until `rxs` is 1, then go to IDLE. A held-low line produces exactly one errored frame, not a stream.
- Latency: rx_valid rises SYNC_STAGES + 1 cycles after the mid-point of the final stop bit on the pin.
- Configuration inputs changing mid-frame have no effect until the next start bit.
- Two-stop frames received while stop2 = 0 are accepted. The extra high bit is seen as idle.
- rx_valid never asserts on consecutive cycles.
- busy is 0 in IDLE only.

Decomposition:
- Shared package `uart_pkg` holds:
  - FSM state encoding;
  - the baud_sel-to-bit-time function (BIT_CLKS_BASE shifts);
  - the len_sel-to-bit-count function;
  - the parity compute function, reused by the transmitter.
- One natural sub-module, `uart_bit_timer`: a loadable down-counter with a terminal-count strobe. The transmitter shares it.
- The synchronizer is inline.

Test Plan:
- Default config (baud 0, len 3, even parity, 1 stop); send 0x3A with parity 0 at 320 ns per bit -> one rx_valid, rx_data = 0x3A, rx_frame = 9'h03A, both error flags 0.
- baud_sel = 1; send 0x3A at 640 ns per bit -> rx_data = 0x3A. Then send 0x7A at 320 ns per bit -> wrong data or frame_err, and no hang (FSM returns to IDLE).
- len_sel = 1 (6 bits); send 6'b111010 with parity 0 -> rx_data = 0x3A, both error flags 0.
- parity_odd = 1; send 0x3A with an even parity bit -> parity_err = 1. Send 0x3A with parity bit 1 -> parity_err = 0.
- stop2 = 1; send 0x3A with the second stop bit forced low -> frame_err = 1. Hold Rx low for 20 bit times -> exactly one rx_valid, busy stays high until Rx goes high.
- Glitch: Rx low for 80 ns -> no rx_valid. Assert rst 5 bit times into a frame -> all outputs 0 immediately, no strobe; the next frame 0x55 decodes correctly.
